cpu_loader: RTL and testbench
=============================

# cpu_loader

Host-side boot controller sitting directly upstream of the `cpu` top. It accepts a 32-bit command/data word stream over a valid/ready handshake and drives the CPU's external memory ports to load instruction memory and data memory, or to read them back. It owns the CPU `enable` input: execution is started and stopped by stream commands, and the memory ports are idle while the CPU runs.

## Interface
- `RD_LAT`, 1: cycles from `ren_ext*` asserted to valid `rdata_ext*` (≥1).
- `ADDR_STEP`, 4: address increment per word.
- `clk` in 1: main clock.
- `arst_n` in 1: reset, asynchronous, active-low.
- `in_data` in 32: command/data word.
- `in_valid` in 1: `in_data` valid.
- `in_ready` out 1: loader accepts `in_data`.
- `rsp_data` out 32: readback word.
- `rsp_valid` out 1: `rsp_data` valid.
- `rsp_ready` in 1: host accepts `rsp_data`.
- `cpu_enable` out 1: to CPU `enable`.
- `addr_ext`, `wdata_ext` out 32; `wen_ext`, `ren_ext` out 1: IMEM ext port.
- `rdata_ext` in 32: IMEM ext read data.
- `addr_ext_2`, `wdata_ext_2` out 32; `wen_ext_2`, `ren_ext_2` out 1: DMEM ext port.
- `rdata_ext_2` in 32: DMEM ext read data.
- `busy` out 1: state ≠ IDLE and ≠ RUN.
- `err` out 1: sticky protocol error.

## Operation
- Handshake: word transfers when `in_valid && in_ready`. Same rule for `rsp_valid && rsp_ready`.
- Header word: `[31:30]` op (00 WRITE, 01 READ, 10 RUN, 11 STOP), `[29]` target (0 IMEM, 1 DMEM), `[28:16]` ignored, `[15:0]` count N.
- The header's target selects the port used for the whole command; the unselected port stays at `wen=0`, `ren=0`.
- States: IDLE, ADDR, WRITE, RD_ISSUE, RD_WAIT, RESP, RUN.
- IDLE:
  - WRITE or READ header → ADDR.
  - RUN → RUN.
  - STOP → no-op, stay IDLE.
- ADDR: next word is the start address A; word counter k = 0.
  - N = 0 → IDLE.
  - Otherwise → WRITE (op WRITE) or RD_ISSUE (op READ).
- WRITE: each accepted word k is written to address A + k·ADDR_STEP. After word N−1 → IDLE.
- RD_ISSUE: one cycle with `ren=1` at A + k·ADDR_STEP → RD_WAIT.
- RD_WAIT: RD_LAT cycles, then capture `rdata` into `rsp_data` → RESP.
- RESP: hold `rsp_valid` until accepted. Then k+1 < N → RD_ISSUE, else → IDLE. One read outstanding at most.
- RUN: `cpu_enable=1`. Memory port strobes are held 0.
  - STOP header (target and count ignored) → IDLE with `cpu_enable=0`.
  - Any other header in RUN is consumed, ignored, and sets `err`.
- Address arithmetic is 32-bit and wraps modulo 2^32. k is 16-bit.
- `err` clears only on reset.

## Timing
- Reset (async assert): state IDLE; every output 0 (`in_ready`, `rsp_*`, `cpu_enable`, all `addr`/`wdata`/`wen`/`ren`, `busy`, `err`). Release is synchronous to `clk`.
- `in_ready`: combinational from state. It is 1 in IDLE, ADDR, WRITE and RUN, and 0 in RD_ISSUE, RD_WAIT and RESP.
- All memory-port outputs are registered. A data word accepted at edge t gives `wen=1` with matching `addr`/`wdata` during cycle t+1 only. Back-to-back accepts give consecutive `wen` cycles.
- `wen`/`ren` are single-cycle pulses. `addr`/`wdata` hold their last value otherwise.
- Read latency per word: header and address are accepted, then `ren` in the next cycle, then `rsp_valid` RD_LAT+1 cycles after the `ren` cycle.
- RUN header accepted at edge t → `cpu_enable=1` from cycle t+1. STOP accepted at edge t → `cpu_enable=0` from cycle t+1.
- Reset mid-command aborts immediately. No partial write completes after `arst_n` falls.

## Test plan
- Load IMEM: headers 0x0000_0003 then 0x0000_0000, then data 0x2001_0005, 0x2002_0007, 0x0022_1820.
  - Three `wen_ext` pulses at addr 0, 4, 8 with those data.
  - `wen_ext_2` stays 0.
  - `busy` falls after the third word.
- Readback DMEM: header 0x6000_0002, addr 0x10, RD_LAT=1, memory holds 0xDEAD_BEEF and 0x1234_5678.
  - `ren_ext_2` pulses at 0x10 and 0x14.
  - `rsp_data` returns both values in order.
  - With `rsp_ready` held 0 for 5 cycles, `rsp_valid` and data stay stable and no second `ren` is issued.
- Run/stop: header 0x8000_0000 gives `cpu_enable=1` the next cycle.
  - A WRITE header sent during RUN sets `err=1`, `cpu_enable` stays 1, and no `wen` is issued.
  - 0xC000_0000 gives `cpu_enable=0` the next cycle.
- Edge counts: N=0 WRITE → back to IDLE after the address word with no strobes. Start addr 0xFFFF_FFFC, N=2 → writes to 0xFFFF_FFFC then 0x0000_0000.
- Reset mid-load: drop `arst_n` after word 1 of 3.
  - All outputs are 0 asynchronously.
  - After release, the next word is treated as a header.
- Throughput: continuous `in_valid` over N=16 → 16 consecutive `wen_ext` cycles with no bubbles.

Source files
------------

// File: rtl/cpu_loader.sv
// ============================================================================
// cpu_loader : host word-stream boot controller for the cpu memory ports
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

module cpu_loader #(
    parameter int RD_LAT    = 1,
    parameter int ADDR_STEP = 4
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        cpu_enable,
    output logic [31:0] addr_ext,
    output logic [31:0] wdata_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    input  logic [31:0] rdata_ext,
    output logic [31:0] addr_ext_2,
    output logic [31:0] wdata_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    input  logic [31:0] rdata_ext_2,
    output logic        busy,
    output logic        err
);

    localparam int          LAT_W    = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
    localparam logic [31:0] STEP     = 32'(ADDR_STEP);
    localparam logic [1:0]  OP_WRITE = 2'b00;
    localparam logic [1:0]  OP_READ  = 2'b01;
    localparam logic [1:0]  OP_RUN   = 2'b10;
    localparam logic [1:0]  OP_STOP  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_WRITE    = 3'd2,
        S_RD_ISSUE = 3'd3,
        S_RD_WAIT  = 3'd4,
        S_RESP     = 3'd5,
        S_RUN      = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic               is_read_q, is_read_d;
    logic               tgt_q, tgt_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [15:0]        k_q, k_d;
    logic [31:0]        cur_addr_q, cur_addr_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [31:0]        rsp_data_q, rsp_data_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               cpu_enable_q, cpu_enable_d;
    logic               err_q, err_d;
    logic [31:0]        addr_ext_q, addr_ext_d, wdata_ext_q, wdata_ext_d;
    logic [31:0]        addr_ext_2_q, addr_ext_2_d, wdata_ext_2_q, wdata_ext_2_d;
    logic               wen_ext_q, wen_ext_d, ren_ext_q, ren_ext_d;
    logic               wen_ext_2_q, wen_ext_2_d, ren_ext_2_q, ren_ext_2_d;

    logic               hs;
    logic               last_word;
    logic               do_wr, do_rd;
    logic [31:0]        port_addr, port_wdata;
    logic               unused_hdr_bits;

    assign unused_hdr_bits = ^in_data[28:16];

    // Gated by the reset pin so in_ready reads 0 while reset is asserted.
    assign in_ready  = arst_n && ((state_q == S_IDLE) || (state_q == S_ADDR) ||
                                  (state_q == S_WRITE) || (state_q == S_RUN));
    assign hs        = in_valid && in_ready;
    assign last_word = (({1'b0, k_q} + 17'd1) == {1'b0, cnt_q});

    always_comb begin
        state_d       = state_q;
        is_read_d     = is_read_q;
        tgt_d         = tgt_q;
        cnt_d         = cnt_q;
        k_d           = k_q;
        cur_addr_d    = cur_addr_q;
        lat_d         = lat_q;
        rsp_data_d    = rsp_data_q;
        rsp_valid_d   = rsp_valid_q;
        cpu_enable_d  = cpu_enable_q;
        err_d         = err_q;
        addr_ext_d    = addr_ext_q;
        wdata_ext_d   = wdata_ext_q;
        addr_ext_2_d  = addr_ext_2_q;
        wdata_ext_2_d = wdata_ext_2_q;
        wen_ext_d     = 1'b0;
        ren_ext_d     = 1'b0;
        wen_ext_2_d   = 1'b0;
        ren_ext_2_d   = 1'b0;
        do_wr         = 1'b0;
        do_rd         = 1'b0;
        port_addr     = cur_addr_q;
        port_wdata    = in_data;

        case (state_q)
            S_IDLE: begin
                if (hs) begin
                    case (in_data[31:30])
                        OP_WRITE, OP_READ: begin
                            is_read_d = (in_data[31:30] == OP_READ);
                            tgt_d     = in_data[29];
                            cnt_d     = in_data[15:0];
                            state_d   = S_ADDR;
                        end
                        OP_RUN: begin
                            cpu_enable_d = 1'b1;
                            state_d      = S_RUN;
                        end
                        default: ;
                    endcase
                end
            end
            S_ADDR: begin
                if (hs) begin
                    k_d        = 16'd0;
                    cur_addr_d = in_data;
                    if (cnt_q == 16'd0) begin
                        state_d = S_IDLE;
                    end else if (is_read_q) begin
                        do_rd     = 1'b1;
                        port_addr = in_data;
                        state_d   = S_RD_ISSUE;
                    end else begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (hs) begin
                    do_wr      = 1'b1;
                    cur_addr_d = cur_addr_q + STEP;
                    k_d        = k_q + 16'd1;
                    if (last_word) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_RD_ISSUE: begin
                lat_d   = LAT_W'(1);
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (lat_q >= LAT_W'(RD_LAT)) begin
                    rsp_data_d  = tgt_q ? rdata_ext_2 : rdata_ext;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (last_word) begin
                        state_d = S_IDLE;
                    end else begin
                        k_d        = k_q + 16'd1;
                        cur_addr_d = cur_addr_q + STEP;
                        do_rd      = 1'b1;
                        port_addr  = cur_addr_q + STEP;
                        state_d    = S_RD_ISSUE;
                    end
                end
            end
            S_RUN: begin
                if (hs) begin
                    if (in_data[31:30] == OP_STOP) begin
                        cpu_enable_d = 1'b0;
                        state_d      = S_IDLE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Route the strobe to the port chosen by the header target.
        if (do_wr || do_rd) begin
            if (tgt_q) begin
                addr_ext_2_d = port_addr;
                wen_ext_2_d  = do_wr;
                ren_ext_2_d  = do_rd;
                if (do_wr) wdata_ext_2_d = port_wdata;
            end else begin
                addr_ext_d = port_addr;
                wen_ext_d  = do_wr;
                ren_ext_d  = do_rd;
                if (do_wr) wdata_ext_d = port_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q       <= S_IDLE;
            is_read_q     <= 1'b0;
            tgt_q         <= 1'b0;
            cnt_q         <= 16'd0;
            k_q           <= 16'd0;
            cur_addr_q    <= 32'd0;
            lat_q         <= '0;
            rsp_data_q    <= 32'd0;
            rsp_valid_q   <= 1'b0;
            cpu_enable_q  <= 1'b0;
            err_q         <= 1'b0;
            addr_ext_q    <= 32'd0;
            wdata_ext_q   <= 32'd0;
            addr_ext_2_q  <= 32'd0;
            wdata_ext_2_q <= 32'd0;
            wen_ext_q     <= 1'b0;
            ren_ext_q     <= 1'b0;
            wen_ext_2_q   <= 1'b0;
            ren_ext_2_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            is_read_q     <= is_read_d;
            tgt_q         <= tgt_d;
            cnt_q         <= cnt_d;
            k_q           <= k_d;
            cur_addr_q    <= cur_addr_d;
            lat_q         <= lat_d;
            rsp_data_q    <= rsp_data_d;
            rsp_valid_q   <= rsp_valid_d;
            cpu_enable_q  <= cpu_enable_d;
            err_q         <= err_d;
            addr_ext_q    <= addr_ext_d;
            wdata_ext_q   <= wdata_ext_d;
            addr_ext_2_q  <= addr_ext_2_d;
            wdata_ext_2_q <= wdata_ext_2_d;
            wen_ext_q     <= wen_ext_d;
            ren_ext_q     <= ren_ext_d;
            wen_ext_2_q   <= wen_ext_2_d;
            ren_ext_2_q   <= ren_ext_2_d;
        end
    end

    assign rsp_data    = rsp_data_q;
    assign rsp_valid   = rsp_valid_q;
    assign cpu_enable  = cpu_enable_q;
    assign err         = err_q;
    assign addr_ext    = addr_ext_q;
    assign wdata_ext   = wdata_ext_q;
    assign wen_ext     = wen_ext_q;
    assign ren_ext     = ren_ext_q;
    assign addr_ext_2  = addr_ext_2_q;
    assign wdata_ext_2 = wdata_ext_2_q;
    assign wen_ext_2   = wen_ext_2_q;
    assign ren_ext_2   = ren_ext_2_q;
    assign busy        = (state_q != S_IDLE) && (state_q != S_RUN);

endmodule

`default_nettype wire

// File: tb/tb_cpu_loader.sv
// ============================================================================
// tb_cpu_loader : scoreboard bench for cpu_loader
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

module tb_cpu_loader;

    localparam int RD_LAT = 1;

    logic        clk = 1'b0;
    logic        arst_n;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rsp_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        cpu_enable;
    logic [31:0] addr_ext, wdata_ext, rdata_ext;
    logic        wen_ext, ren_ext;
    logic [31:0] addr_ext_2, wdata_ext_2, rdata_ext_2;
    logic        wen_ext_2, ren_ext_2;
    logic        busy, err;

    always #5 clk = ~clk;

    cpu_loader #(.RD_LAT(RD_LAT), .ADDR_STEP(4)) dut (
        .clk(clk), .arst_n(arst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .cpu_enable(cpu_enable),
        .addr_ext(addr_ext), .wdata_ext(wdata_ext), .wen_ext(wen_ext),
        .ren_ext(ren_ext), .rdata_ext(rdata_ext),
        .addr_ext_2(addr_ext_2), .wdata_ext_2(wdata_ext_2), .wen_ext_2(wen_ext_2),
        .ren_ext_2(ren_ext_2), .rdata_ext_2(rdata_ext_2),
        .busy(busy), .err(err)
    );

    typedef struct packed {
        logic [1:0]  kind;   // 0 wen imem, 1 wen dmem, 2 ren imem, 3 ren dmem
        logic [31:0] addr;
        logic [31:0] data;
    } strobe_t;

    strobe_t     sq[$];
    logic [31:0] rq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_ren = 0;
    int          ren2_cnt = 0;
    int          run_len = 0;
    int          last_run = 0;
    logic        rsp_valid_prev = 1'b0;
    logic [31:0] imem [64];
    logic [31:0] dmem [64];

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic take_strobe(input logic [1:0] kind, input logic [31:0] a, input logic [31:0] d);
        strobe_t e;
        check("strobe_pending", 72'(sq.size() != 0), 72'(1));
        if (sq.size() != 0) begin
            e = sq.pop_front();
            check("strobe", 72'({kind, a, d}), 72'(e));
        end
    endtask

    // Memory models: one cycle read latency.
    always @(posedge clk) begin
        if (ren_ext)   rdata_ext   <= imem[addr_ext[7:2]];
        if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[7:2]];
    end

    // Monitor samples at the falling edge, away from the active edge.
    always @(negedge clk) begin
        cyc++;
        if (arst_n) begin
            if (wen_ext)   take_strobe(2'd0, addr_ext,   wdata_ext);
            if (wen_ext_2) take_strobe(2'd1, addr_ext_2, wdata_ext_2);
            if (ren_ext)   take_strobe(2'd2, addr_ext,   32'd0);
            if (ren_ext_2) take_strobe(2'd3, addr_ext_2, 32'd0);
            if (ren_ext || ren_ext_2) last_ren = cyc;
            if (ren_ext_2) ren2_cnt++;
            if (rsp_valid && !rsp_valid_prev)
                check("rd_lat", 72'(cyc - last_ren), 72'(RD_LAT + 1));
            if (rsp_valid && rsp_ready) begin
                check("rsp_pending", 72'(rq.size() != 0), 72'(1));
                if (rq.size() != 0) check("rsp_data", 72'(rsp_data), 72'(rq.pop_front()));
            end
            if (wen_ext) begin
                run_len++;
            end else begin
                if (run_len != 0) last_run = run_len;
                run_len = 0;
            end
        end
        rsp_valid_prev = rsp_valid;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic send(input logic [31:0] w);
        int n = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            tick(1);
            n++;
        end
        check("send_timeout", 72'(in_ready), 72'(1));
        tick(1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, 72'({in_ready, rsp_valid, cpu_enable, wen_ext, ren_ext,
                                  wen_ext_2, ren_ext_2, busy, err}), 72'(0));
        check({tag, "_bus"}, 72'(addr_ext | wdata_ext | addr_ext_2 | wdata_ext_2 | rsp_data),
              72'(0));
    endtask

    initial begin
        int n;
        int base;
        arst_n      = 1'b0;
        in_valid    = 1'b0;
        in_data     = 32'd0;
        rsp_ready   = 1'b1;
        rdata_ext   = 32'd0;
        rdata_ext_2 = 32'd0;
        for (int i = 0; i < 64; i++) begin
            imem[i] = 32'h0;
            dmem[i] = 32'h0;
        end
        dmem[4] = 32'hDEAD_BEEF;
        dmem[5] = 32'h1234_5678;

        #1;
        check_all_zero("reset");
        tick(3);
        arst_n = 1'b1;
        tick(1);
        check("idle_ready", 72'(in_ready), 72'(1));

        // IMEM load of three words
        sq.push_back('{2'd0, 32'h0, 32'h2001_0005});
        sq.push_back('{2'd0, 32'h4, 32'h2002_0007});
        sq.push_back('{2'd0, 32'h8, 32'h0022_1820});
        send(32'h0000_0003);
        send(32'h0000_0000);
        check("busy_load", 72'(busy), 72'(1));
        send(32'h2001_0005);
        send(32'h2002_0007);
        send(32'h0022_1820);
        in_valid = 1'b0;
        check("busy_fall", 72'(busy), 72'(0));
        tick(2);
        check("load_drain", 72'(sq.size()), 72'(0));

        // DMEM readback with a stalled response
        rsp_ready = 1'b0;
        base = ren2_cnt;
        sq.push_back('{2'd3, 32'h10, 32'h0});
        sq.push_back('{2'd3, 32'h14, 32'h0});
        rq.push_back(32'hDEAD_BEEF);
        rq.push_back(32'h1234_5678);
        send(32'h6000_0002);
        send(32'h0000_0010);
        in_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin
            tick(1);
            n++;
        end
        check("rsp_timeout", 72'(rsp_valid), 72'(1));
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("stall_valid", 72'(rsp_valid), 72'(1));
            check("stall_data", 72'(rsp_data), 72'(32'hDEAD_BEEF));
            check("stall_ren", 72'(ren2_cnt - base), 72'(1));
            check("stall_ready", 72'(in_ready), 72'(0));
        end
        rsp_ready = 1'b1;
        n = 0;
        while ((rq.size() != 0 || busy) && n < 50) begin
            tick(1);
            n++;
        end
        check("rd_done", 72'(rq.size()), 72'(0));
        check("rd_ren_cnt", 72'(ren2_cnt - base), 72'(2));
        check("rd_drain", 72'(sq.size()), 72'(0));

        // Run / stop with an illegal header while running
        send(32'h8000_0000);
        in_valid = 1'b0;
        check("run_en", 72'(cpu_enable), 72'(1));
        check("run_busy", 72'(busy), 72'(0));
        send(32'h0000_0001);
        in_valid = 1'b0;
        check("run_err", 72'(err), 72'(1));
        check("run_en_hold", 72'(cpu_enable), 72'(1));
        tick(2);
        send(32'hC000_0000);
        in_valid = 1'b0;
        check("stop_en", 72'(cpu_enable), 72'(0));

        // Zero-length write, then address wrap
        send(32'h0000_0000);
        send(32'h0000_0040);
        in_valid = 1'b0;
        check("n0_idle", 72'(busy), 72'(0));
        sq.push_back('{2'd0, 32'hFFFF_FFFC, 32'hA5A5_0001});
        sq.push_back('{2'd0, 32'h0000_0000, 32'h5A5A_0002});
        send(32'h0000_0002);
        send(32'hFFFF_FFFC);
        send(32'hA5A5_0001);
        send(32'h5A5A_0002);
        in_valid = 1'b0;
        tick(2);
        check("wrap_drain", 72'(sq.size()), 72'(0));

        // Reset in the middle of a load
        send(32'h0000_0003);
        send(32'h0000_0000);
        send(32'h1111_1111);
        in_valid = 1'b0;
        arst_n   = 1'b0;
        #1;
        check_all_zero("midrst");
        tick(2);
        arst_n = 1'b1;
        tick(1);
        send(32'h8000_0000);
        in_valid = 1'b0;
        check("post_rst_hdr", 72'(cpu_enable), 72'(1));
        check("post_rst_err", 72'(err), 72'(0));
        send(32'hC000_0000);
        in_valid = 1'b0;
        check("post_rst_stop", 72'(cpu_enable), 72'(0));

        // Sixteen back-to-back words
        for (int i = 0; i < 16; i++)
            sq.push_back('{2'd0, 32'h100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i)});
        send(32'h0000_0010);
        send(32'h0000_0100);
        for (int i = 0; i < 16; i++)
            send(32'hC0DE_0000 + 32'(i));
        in_valid = 1'b0;
        tick(3);
        check("burst_run", 72'(last_run), 72'(16));
        check("burst_drain", 72'(sq.size()), 72'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
